dl_report_arbiter: RTL and testbench
====================================

# dl_report_arbiter

Synthesizable deadlock arbiter and reporter that closes the loop opened by the per-process deadlock detect units. It receives each unit's `dl_detect_out` bit and elects a single origin process by a one-hot `origin` grant. It confirms the suspected cycle over a programmable window, then either releases it with a `token_clear` pulse or latches the deadlock. After latching, it streams one diagnostic record per blocked process over a valid/ready interface to an on-chip logger. It sits at the top of the dataflow region, beside the detect-unit ring, and drives the `dl_detect_in`, `origin` and `token_clear` inputs of every unit.

## Interface
- PROC_NUM, 2, number of monitored processes (≥1)
- CNT_W, 16, width of each transaction counter
- CONFIRM_CYCLES, 4, cycles the origin's bit must stay high before a deadlock is latched (≥1)
- IDX_W, derived: max(1, clog2(PROC_NUM))

Ports:
- dl_clock  in  1  single clock; all logic on rising edge
- dl_reset  in  1  synchronous, active-high reset
- dl_in_vec  in  PROC_NUM  per-process detect bits from the detect units
- all_finish  in  1  design finished; masks dl_in_vec
- trans_in_cnt  in  PROC_NUM*CNT_W  process i occupies [i*CNT_W +: CNT_W]
- trans_out_cnt  in  PROC_NUM*CNT_W  same packing
- ap_done_reg  in  PROC_NUM  per-process done-but-not-continued flags
- dl_detect_out  out  1  deadlock latched; freezes the detect units
- origin  out  PROC_NUM  one-hot elected origin, or zero
- token_clear  out  1  one-cycle release pulse
- rpt_valid  out  1  report record valid
- rpt_ready  in  1  logger accepts record
- rpt_proc_id  out  IDX_W  blocked process index
- rpt_in_cnt / rpt_out_cnt  out  CNT_W  counter snapshot for rpt_proc_id
- rpt_done_flag  out  1  ap_done_reg snapshot for rpt_proc_id
- rpt_last  out  1  final record of the report

## Operation
- Masked request: m = dl_in_vec & ~{PROC_NUM{all_finish}}.
- FSM states: IDLE, TRACE, CLEAR, REPORT, DONE.
- IDLE
  - origin = 0 and dl_detect_out = 0.
  - If m ≠ 0: origin ← one-hot of the lowest set bit of m, conf_cnt ← 0, go to TRACE.
- TRACE
  - origin is held.
  - If all_finish = 1 or dl_in_vec[sel] = 0: go to CLEAR. This has priority over confirmation.
  - Else if conf_cnt = CONFIRM_CYCLES−1: go to REPORT. On entry:
    - dl_detect_out ← 1.
    - snap_mask ← dl_in_vec.
    - All rpt_* fields and counters are snapshotted.
  - Else conf_cnt increments.
- CLEAR
  - token_clear = 1 for exactly this cycle.
  - origin ← 0, then go to IDLE.
  - No new election occurs in the CLEAR cycle.
- REPORT
  - Walk snap_mask from lowest to highest set bit, one record per bit.
  - rpt_valid = 1 with fields for the current bit. rpt_last = 1 on the highest set bit.
  - Fields stay stable while rpt_valid & ~rpt_ready.
  - On rpt_valid & rpt_ready: advance. After the last bit, go to DONE.
  - snap_mask always contains the origin bit, so it is never empty.
- DONE
  - dl_detect_out = 1 and origin is held.
  - rpt_valid = 0. The block stays here until dl_reset.
- all_finish is ignored in REPORT and DONE; a latched deadlock is never retracted.
- Counters are snapshotted once at latch time. Live changes afterwards are not reported.

## Timing
- Reset values (asserted dl_reset at a clock edge):
  - State = IDLE.
  - dl_detect_out = 0, origin = 0, token_clear = 0.
  - rpt_valid = 0, rpt_last = 0, rpt_proc_id = 0, rpt_in_cnt = 0, rpt_out_cnt = 0, rpt_done_flag = 0.
  - conf_cnt = 0, snap_mask = 0.
- Reset mid-REPORT drops rpt_valid on the next edge with no completion handshake.
- Election latency: m seen at edge t gives origin valid after edge t.
- Latch latency: deadlock latched CONFIRM_CYCLES edges after origin is asserted, provided dl_in_vec[sel] stays high throughout.
- First record: rpt_valid rises on the same edge as dl_detect_out.
- Throughput: one record per cycle when rpt_ready is held high.
- All outputs are registered. No combinational path from any input to any output.
- Simultaneous requests: lowest index wins. Other requesters are reported only if set at latch time.

## Test plan
- PROC_NUM=2, dl_in_vec=2'b11 held, rpt_ready=1:
  - origin=01 one cycle after the request.
  - dl_detect_out=1 four cycles later.
  - Record id0 (rpt_last=0), then record id1 (rpt_last=1).
  - DONE is held thereafter.
- dl_in_vec=2'b10 for 2 cycles, then 0:
  - origin=10.
  - token_clear high for exactly one cycle.
  - origin=0, back to IDLE, dl_detect_out never set.
- all_finish asserted in TRACE with dl_in_vec=2'b01 → CLEAR pulse, no report. all_finish held with dl_in_vec=11 in IDLE → no election.
- Latch with trans_in_cnt={16'd5,16'd9}, trans_out_cnt={16'd5,16'd8}, ap_done_reg=2'b01, rpt_ready low for 3 cycles:
  - Record id0 (in=9, out=8, done=1) is held stable for the stall.
  - Then record id1 (in=5, out=5, done=0, rpt_last=1).
- dl_reset asserted during REPORT:
  - Next cycle all outputs are at reset values.
  - A fresh request re-elects and re-confirms from conf_cnt=0.

Source files
------------

// File: rtl/dl_report_arbiter.sv
// dl_report_arbiter
// Elects one origin among the processes whose deadlock-detect bits are set,
// confirms that the origin's bit stays high for CONFIRM_CYCLES cycles, and
// either releases the suspicion with a one-cycle token_clear pulse or latches
// the deadlock. Once latched, it streams one diagnostic record per blocked
// process (as seen at latch time) over a valid/ready interface.
//
// Ports
//   dl_clock, dl_reset       clock and synchronous active-high reset
//   dl_in_vec                per-process detect bits from the detect units
//   all_finish               design finished; masks dl_in_vec
//   trans_in_cnt/out_cnt     packed per-process counters, process i at [i*CNT_W +: CNT_W]
//   ap_done_reg              per-process done-but-not-continued flags
//   dl_detect_out            deadlock latched (freezes the detect units)
//   origin                   one-hot elected origin, or zero
//   token_clear              one-cycle release pulse
//   rpt_valid/rpt_ready      report record handshake
//   rpt_proc_id, rpt_in_cnt, rpt_out_cnt, rpt_done_flag, rpt_last
//                            record fields (snapshot values) and end-of-report flag
module dl_report_arbiter #(
   parameter int PROC_NUM       = 2,
   parameter int CNT_W          = 16,
   parameter int CONFIRM_CYCLES = 4,
   localparam int IDX_W         = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
   input  logic                      dl_clock,
   input  logic                      dl_reset,
   input  logic [PROC_NUM-1:0]       dl_in_vec,
   input  logic                      all_finish,
   input  logic [PROC_NUM*CNT_W-1:0] trans_in_cnt,
   input  logic [PROC_NUM*CNT_W-1:0] trans_out_cnt,
   input  logic [PROC_NUM-1:0]       ap_done_reg,
   output logic                      dl_detect_out,
   output logic [PROC_NUM-1:0]       origin,
   output logic                      token_clear,
   output logic                      rpt_valid,
   input  logic                      rpt_ready,
   output logic [IDX_W-1:0]          rpt_proc_id,
   output logic [CNT_W-1:0]          rpt_in_cnt,
   output logic [CNT_W-1:0]          rpt_out_cnt,
   output logic                      rpt_done_flag,
   output logic                      rpt_last
);

   localparam int CONF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
   localparam logic [CONF_W-1:0]   CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);
   localparam logic [PROC_NUM-1:0] ONE       = PROC_NUM'(1);

   typedef enum logic [2:0] {IDLE, TRACE, CLEAR, REPORT, DONE} state_t;

   state_t              state, state_n;
   logic [IDX_W-1:0]    sel, sel_n;
   logic [CONF_W-1:0]   conf_cnt, conf_cnt_n;
   logic [PROC_NUM-1:0] snap_mask, snap_mask_n;
   logic [PROC_NUM-1:0] origin_n;
   logic                det_n, tc_n, valid_n, last_n, done_n;
   logic [IDX_W-1:0]    id_n;
   logic [CNT_W-1:0]    in_n, out_n;
   logic                latch;
   logic [PROC_NUM-1:0] m, rest;
   logic [IDX_W-1:0]    nid;

   logic [CNT_W-1:0]    snap_in  [PROC_NUM];
   logic [CNT_W-1:0]    snap_out [PROC_NUM];
   logic [PROC_NUM-1:0] snap_done;

   // Index of the lowest set bit; zero when the vector is empty.
   function automatic logic [IDX_W-1:0] low_idx(input logic [PROC_NUM-1:0] v);
      low_idx = '0;
      for (int unsigned i = PROC_NUM; i > 0; i--) begin
         if (v[i-1]) low_idx = IDX_W'(i - 1);
      end
   endfunction

   // True when at most one bit is set, i.e. the current record is the last.
   function automatic logic one_left(input logic [PROC_NUM-1:0] v);
      one_left = ((v & (v - ONE)) == '0);
   endfunction

   assign m = dl_in_vec & ~{PROC_NUM{all_finish}};

   always_comb begin
      state_n     = state;
      sel_n       = sel;
      conf_cnt_n  = conf_cnt;
      snap_mask_n = snap_mask;
      origin_n    = origin;
      det_n       = dl_detect_out;
      tc_n        = 1'b0;
      valid_n     = rpt_valid;
      last_n      = rpt_last;
      id_n        = rpt_proc_id;
      in_n        = rpt_in_cnt;
      out_n       = rpt_out_cnt;
      done_n      = rpt_done_flag;
      latch       = 1'b0;
      rest        = '0;
      nid         = '0;
      case (state)
         IDLE: begin
            origin_n = '0;
            det_n    = 1'b0;
            if (m != '0) begin
               sel_n      = low_idx(m);
               origin_n   = ONE << low_idx(m);
               conf_cnt_n = '0;
               state_n    = TRACE;
            end
         end
         TRACE: begin
            if (all_finish || !dl_in_vec[sel]) begin
               state_n = CLEAR;
               tc_n    = 1'b1;
            end else if (conf_cnt == CONF_LAST) begin
               // First record is loaded straight from the live inputs, which
               // are the values being snapshotted on this same edge.
               state_n     = REPORT;
               latch       = 1'b1;
               det_n       = 1'b1;
               snap_mask_n = dl_in_vec;
               id_n        = low_idx(dl_in_vec);
               in_n        = trans_in_cnt[int'(low_idx(dl_in_vec))*CNT_W +: CNT_W];
               out_n       = trans_out_cnt[int'(low_idx(dl_in_vec))*CNT_W +: CNT_W];
               done_n      = ap_done_reg[low_idx(dl_in_vec)];
               valid_n     = 1'b1;
               last_n      = one_left(dl_in_vec);
            end else begin
               conf_cnt_n = conf_cnt + CONF_W'(1);
            end
         end
         CLEAR: begin
            origin_n = '0;
            state_n  = IDLE;
         end
         REPORT: begin
            if (rpt_ready) begin
               // snap_mask shrinks as records are accepted; the remaining
               // lowest bit is the next record.
               rest        = snap_mask & ~(ONE << rpt_proc_id);
               snap_mask_n = rest;
               if (rpt_last) begin
                  state_n = DONE;
                  valid_n = 1'b0;
                  last_n  = 1'b0;
               end else begin
                  nid    = low_idx(rest);
                  id_n   = nid;
                  in_n   = snap_in[nid];
                  out_n  = snap_out[nid];
                  done_n = snap_done[nid];
                  last_n = one_left(rest);
               end
            end
         end
         DONE: begin
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge dl_clock) begin
      if (dl_reset) begin
         state         <= IDLE;
         sel           <= '0;
         conf_cnt      <= '0;
         snap_mask     <= '0;
         origin        <= '0;
         dl_detect_out <= 1'b0;
         token_clear   <= 1'b0;
         rpt_valid     <= 1'b0;
         rpt_last      <= 1'b0;
         rpt_proc_id   <= '0;
         rpt_in_cnt    <= '0;
         rpt_out_cnt   <= '0;
         rpt_done_flag <= 1'b0;
      end else begin
         state         <= state_n;
         sel           <= sel_n;
         conf_cnt      <= conf_cnt_n;
         snap_mask     <= snap_mask_n;
         origin        <= origin_n;
         dl_detect_out <= det_n;
         token_clear   <= tc_n;
         rpt_valid     <= valid_n;
         rpt_last      <= last_n;
         rpt_proc_id   <= id_n;
         rpt_in_cnt    <= in_n;
         rpt_out_cnt   <= out_n;
         rpt_done_flag <= done_n;
      end
   end

   // Counter snapshot taken once, on the latch edge.
   always_ff @(posedge dl_clock) begin
      if (latch) begin
         for (int unsigned i = 0; i < PROC_NUM; i++) begin
            snap_in[i]   <= trans_in_cnt[i*CNT_W +: CNT_W];
            snap_out[i]  <= trans_out_cnt[i*CNT_W +: CNT_W];
            snap_done[i] <= ap_done_reg[i];
         end
      end
   end

endmodule

// File: tb/tb_dl_report_arbiter.sv
module tb_dl_report_arbiter;

   logic        dl_clock = 1'b0;
   logic        dl_reset;
   logic [1:0]  dl_in_vec;
   logic        all_finish;
   logic [31:0] trans_in_cnt;
   logic [31:0] trans_out_cnt;
   logic [1:0]  ap_done_reg;
   logic        dl_detect_out;
   logic [1:0]  origin;
   logic        token_clear;
   logic        rpt_valid;
   logic        rpt_ready;
   logic [0:0]  rpt_proc_id;
   logic [15:0] rpt_in_cnt;
   logic [15:0] rpt_out_cnt;
   logic        rpt_done_flag;
   logic        rpt_last;

   int total = 0;
   int bad   = 0;

   dl_report_arbiter #(
      .PROC_NUM(2),
      .CNT_W(16),
      .CONFIRM_CYCLES(4)
   ) dut (
      .dl_clock(dl_clock),
      .dl_reset(dl_reset),
      .dl_in_vec(dl_in_vec),
      .all_finish(all_finish),
      .trans_in_cnt(trans_in_cnt),
      .trans_out_cnt(trans_out_cnt),
      .ap_done_reg(ap_done_reg),
      .dl_detect_out(dl_detect_out),
      .origin(origin),
      .token_clear(token_clear),
      .rpt_valid(rpt_valid),
      .rpt_ready(rpt_ready),
      .rpt_proc_id(rpt_proc_id),
      .rpt_in_cnt(rpt_in_cnt),
      .rpt_out_cnt(rpt_out_cnt),
      .rpt_done_flag(rpt_done_flag),
      .rpt_last(rpt_last)
   );

   always #5 dl_clock = ~dl_clock;

   // Advance one rising edge, then settle 1 ns so outputs are sampled away
   // from the edge and new inputs are set up well before the next one.
   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge dl_clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rec(input string tag, input logic v, input logic [0:0] id,
                          input logic [15:0] ic, input logic [15:0] oc,
                          input logic d, input logic l);
      chk({tag, "_valid"}, 32'(rpt_valid), 32'(v));
      chk({tag, "_id"},    32'(rpt_proc_id), 32'(id));
      chk({tag, "_in"},    32'(rpt_in_cnt), 32'(ic));
      chk({tag, "_out"},   32'(rpt_out_cnt), 32'(oc));
      chk({tag, "_done"},  32'(rpt_done_flag), 32'(d));
      chk({tag, "_last"},  32'(rpt_last), 32'(l));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_det"},    32'(dl_detect_out), 32'd0);
      chk({tag, "_origin"}, 32'(origin), 32'd0);
      chk({tag, "_tc"},     32'(token_clear), 32'd0);
      chk_rec(tag, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
   endtask

   initial begin
      dl_reset      = 1'b1;
      dl_in_vec     = 2'b00;
      all_finish    = 1'b0;
      trans_in_cnt  = '0;
      trans_out_cnt = '0;
      ap_done_reg   = 2'b00;
      rpt_ready     = 1'b0;
      #2;
      step(2);
      chk_reset_vals("rst");
      dl_reset = 1'b0;

      // Both processes blocked, logger always ready.
      trans_in_cnt  = {16'd3, 16'd7};
      trans_out_cnt = {16'd2, 16'd6};
      ap_done_reg   = 2'b10;
      rpt_ready     = 1'b1;
      dl_in_vec     = 2'b11;
      step();
      chk("t1_origin", 32'(origin), 32'h1);
      chk("t1_det0", 32'(dl_detect_out), 32'd0);
      step(3);
      chk("t1_det_pre", 32'(dl_detect_out), 32'd0);
      chk("t1_valid_pre", 32'(rpt_valid), 32'd0);
      step();
      chk("t1_det", 32'(dl_detect_out), 32'd1);
      chk_rec("t1_r0", 1'b1, 1'b0, 16'd7, 16'd6, 1'b0, 1'b0);
      step();
      chk_rec("t1_r1", 1'b1, 1'b1, 16'd3, 16'd2, 1'b1, 1'b1);
      step();
      chk("t1_done_valid", 32'(rpt_valid), 32'd0);
      chk("t1_done_det", 32'(dl_detect_out), 32'd1);
      chk("t1_done_origin", 32'(origin), 32'h1);
      all_finish = 1'b1;
      dl_in_vec  = 2'b00;
      step(3);
      chk("t1_hold_det", 32'(dl_detect_out), 32'd1);
      chk("t1_hold_origin", 32'(origin), 32'h1);
      chk("t1_hold_valid", 32'(rpt_valid), 32'd0);
      all_finish = 1'b0;

      dl_reset = 1'b1;
      step();
      chk_reset_vals("rst2");
      dl_reset = 1'b0;

      // Suspicion on process 1 that evaporates before confirmation.
      dl_in_vec = 2'b10;
      step();
      chk("t2_origin", 32'(origin), 32'h2);
      step();
      chk("t2_tc0", 32'(token_clear), 32'd0);
      dl_in_vec = 2'b00;
      step();
      chk("t2_tc", 32'(token_clear), 32'd1);
      step();
      chk("t2_tc_off", 32'(token_clear), 32'd0);
      chk("t2_origin0", 32'(origin), 32'd0);
      step();
      chk("t2_tc_off2", 32'(token_clear), 32'd0);
      chk("t2_det", 32'(dl_detect_out), 32'd0);

      // all_finish during TRACE forces a release; then masks election.
      dl_in_vec = 2'b01;
      step();
      chk("t3_origin", 32'(origin), 32'h1);
      all_finish = 1'b1;
      step();
      chk("t3_tc", 32'(token_clear), 32'd1);
      dl_in_vec = 2'b11;
      step();
      chk("t3_tc_off", 32'(token_clear), 32'd0);
      chk("t3_origin0", 32'(origin), 32'd0);
      step(6);
      chk("t3_no_elect", 32'(origin), 32'd0);
      chk("t3_det", 32'(dl_detect_out), 32'd0);
      chk("t3_valid", 32'(rpt_valid), 32'd0);
      all_finish = 1'b0;
      dl_in_vec  = 2'b00;
      step();

      // Latch with logger stalled; live counter changes must not leak in.
      trans_in_cnt  = {16'd5, 16'd9};
      trans_out_cnt = {16'd5, 16'd8};
      ap_done_reg   = 2'b01;
      rpt_ready     = 1'b0;
      dl_in_vec     = 2'b11;
      step();
      chk("t4_origin", 32'(origin), 32'h1);
      step(4);
      chk("t4_det", 32'(dl_detect_out), 32'd1);
      chk_rec("t4_r0", 1'b1, 1'b0, 16'd9, 16'd8, 1'b1, 1'b0);
      trans_in_cnt  = {16'd77, 16'd66};
      trans_out_cnt = {16'd55, 16'd44};
      ap_done_reg   = 2'b10;
      for (int s = 0; s < 3; s++) begin
         step();
         chk_rec("t4_stall", 1'b1, 1'b0, 16'd9, 16'd8, 1'b1, 1'b0);
      end
      rpt_ready = 1'b1;
      step();
      chk_rec("t4_r1", 1'b1, 1'b1, 16'd5, 16'd5, 1'b0, 1'b1);
      step();
      chk("t4_end_valid", 32'(rpt_valid), 32'd0);
      chk("t4_end_det", 32'(dl_detect_out), 32'd1);

      dl_reset = 1'b1;
      step();
      dl_reset = 1'b0;

      // Reset in the middle of a stalled report, then re-election.
      rpt_ready = 1'b0;
      dl_in_vec = 2'b11;
      step(5);
      chk("t5_valid", 32'(rpt_valid), 32'd1);
      dl_reset = 1'b1;
      step();
      chk_reset_vals("t5_rst");
      dl_reset  = 1'b0;
      rpt_ready = 1'b1;
      step();
      chk("t5_origin", 32'(origin), 32'h1);
      step(3);
      chk("t5_det_pre", 32'(dl_detect_out), 32'd0);
      step();
      chk("t5_det", 32'(dl_detect_out), 32'd1);
      chk("t5_valid2", 32'(rpt_valid), 32'd1);
      chk("t5_id", 32'(rpt_proc_id), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
